// File: rtl/tx_uart.sv
// UART transmitter: start bit, LSB-first data, optional even parity, one stop bit.
// Define TX_PARITY_EN to include the even-parity bit (8E1); leave it undefined for 8N1.
module tx_uart #(
  parameter int INPUT_DATA_WIDTH = 8,
  parameter int CLKS_PER_BIT     = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [INPUT_DATA_WIDTH-1:0] tx_data,
  input  logic                        data_valid,
  output logic                        serial_out,
  output logic                        tx_busy,
  output logic                        tx_done
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = (INPUT_DATA_WIDTH > 1) ? $clog2(INPUT_DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(INPUT_DATA_WIDTH - 1);

`ifdef TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t                      state, state_next;
  logic [CNT_W-1:0]            baud_cnt, baud_cnt_next;
  logic [IDX_W-1:0]            bit_idx, bit_idx_next;
  logic [INPUT_DATA_WIDTH-1:0] shift_reg, shift_next, shift_rsh;
  logic                        serial_next, busy_next, done_next;
  logic                        bit_end;
`ifdef TX_PARITY_EN
  logic                        parity_bit, parity_next;
`endif

  assign bit_end   = (baud_cnt == CNT_LAST);
  assign shift_rsh = shift_reg >> 1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      baud_cnt   <= '0;
      bit_idx    <= '0;
      shift_reg  <= '0;
      serial_out <= 1'b1;
      tx_busy    <= 1'b0;
      tx_done    <= 1'b0;
`ifdef TX_PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else begin
      state      <= state_next;
      baud_cnt   <= baud_cnt_next;
      bit_idx    <= bit_idx_next;
      shift_reg  <= shift_next;
      serial_out <= serial_next;
      tx_busy    <= busy_next;
      tx_done    <= done_next;
`ifdef TX_PARITY_EN
      parity_bit <= parity_next;
`endif
    end
  end

  // serial_next holds the line value for the state being entered, so the pin stays registered
  always_comb begin
    state_next    = state;
    baud_cnt_next = baud_cnt;
    bit_idx_next  = bit_idx;
    shift_next    = shift_reg;
    serial_next   = serial_out;
    busy_next     = tx_busy;
    done_next     = 1'b0;
`ifdef TX_PARITY_EN
    parity_next   = parity_bit;
`endif

    if (state != IDLE) begin
      baud_cnt_next = bit_end ? '0 : baud_cnt + 1'b1;
    end

    case (state)
      IDLE: begin
        serial_next   = 1'b1;
        busy_next     = 1'b0;
        baud_cnt_next = '0;
        bit_idx_next  = '0;
        if (data_valid) begin
          shift_next  = tx_data;
`ifdef TX_PARITY_EN
          parity_next = ^tx_data;
`endif
          serial_next = 1'b0;
          busy_next   = 1'b1;
          state_next  = START;
        end
      end
      START: begin
        if (bit_end) begin
          state_next   = DATA;
          bit_idx_next = '0;
          serial_next  = shift_reg[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_idx == IDX_LAST) begin
`ifdef TX_PARITY_EN
            state_next  = PARITY;
            serial_next = parity_bit;
`else
            state_next  = STOP;
            serial_next = 1'b1;
`endif
          end else begin
            bit_idx_next = bit_idx + 1'b1;
            shift_next   = shift_rsh;
            serial_next  = shift_rsh[0];
          end
        end
      end
`ifdef TX_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          state_next  = STOP;
          serial_next = 1'b1;
        end
      end
`endif
      STOP: begin
        if (bit_end) begin
          state_next  = IDLE;
          serial_next = 1'b1;
          busy_next   = 1'b0;
          done_next   = 1'b1;
        end
      end
      default: begin
        state_next  = IDLE;
        serial_next = 1'b1;
        busy_next   = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_tx_uart.sv
// Directed self-checking bench for tx_uart; expected frames are rebuilt from each byte.
// Expectations follow TX_PARITY_EN the same way the design does.
module tb_tx_uart;

  localparam int W   = 8;
  localparam int CPB = 16;

  logic         clk;
  logic         reset;
  logic [W-1:0] tx_data;
  logic         data_valid;
  logic         serial_out;
  logic         tx_busy;
  logic         tx_done;

  int vec_count = 0;
  int err_count = 0;

  tx_uart #(.INPUT_DATA_WIDTH(W), .CLKS_PER_BIT(CPB)) dut (
    .clk        (clk),
    .reset      (reset),
    .tx_data    (tx_data),
    .data_valid (data_valid),
    .serial_out (serial_out),
    .tx_busy    (tx_busy),
    .tx_done    (tx_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic [W-1:0] data, input logic valid);
    tx_data    = data;
    data_valid = valid;
  endtask

  task automatic checkOutput(input string tag, input logic observed, input logic expected);
    vec_count++;
    assert (observed === expected) else begin
      err_count++;
      $error("[TB] FAIL %s observed=%b expected=%b t=%0t", tag, observed, expected, $time);
    end
  endtask

  task automatic checkIdle(input string tag, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      checkOutput({tag, " serial"}, serial_out, 1'b1);
      checkOutput({tag, " busy"}, tx_busy, 1'b0);
      checkOutput({tag, " done"}, tx_done, 1'b0);
    end
  endtask

  // Called at the negedge before the acceptance edge; ends on the tx_done cycle.
  // hold keeps data_valid high for a back-to-back frame of ~data; inject pokes a request mid-frame.
  task automatic checkFrame(input logic [W-1:0] data, input bit hold, input bit inject,
                            input logic [W-1:0] inject_data);
    logic [0:W+2] bits;
    int           nbits;
    int           cyc;
    bits[0] = 1'b0;
    for (int i = 0; i < W; i++) bits[i+1] = data[i];
`ifdef TX_PARITY_EN
    bits[W+1] = ^data;
    bits[W+2] = 1'b1;
    nbits     = W + 3;
`else
    bits[W+1] = 1'b1;
    bits[W+2] = 1'b1;
    nbits     = W + 2;
`endif
    for (int b = 0; b < nbits; b++) begin
      for (int c = 0; c < CPB; c++) begin
        @(negedge clk);
        cyc = b * CPB + c;
        if (cyc == 0) begin
          tx_data = ~data;
          if (!hold) data_valid = 1'b0;
        end
        if (inject && cyc == 50) applyStimulus(inject_data, 1'b1);
        if (inject && cyc == 51) data_valid = 1'bx;
        if (inject && cyc == 54) data_valid = 1'b0;
        checkOutput($sformatf("byte %02h bit%0d cyc%0d serial", data, b, cyc), serial_out, bits[b]);
        checkOutput($sformatf("byte %02h cyc%0d busy", data, cyc), tx_busy, 1'b1);
        checkOutput($sformatf("byte %02h cyc%0d done", data, cyc), tx_done, 1'b0);
      end
    end
    @(negedge clk);
    checkOutput($sformatf("byte %02h end done", data), tx_done, 1'b1);
    checkOutput($sformatf("byte %02h end busy", data), tx_busy, 1'b0);
    checkOutput($sformatf("byte %02h end serial", data), serial_out, 1'b1);
  endtask

  initial begin
    reset = 1'b1;
    applyStimulus(8'h00, 1'b0);

    // async reset before any clock edge
    #2 reset = 1'b0;
    #1;
    checkOutput("por serial", serial_out, 1'b1);
    checkOutput("por busy", tx_busy, 1'b0);
    checkOutput("por done", tx_done, 1'b0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    checkIdle("post-reset idle", 3);

    applyStimulus(8'hA5, 1'b1);
    checkFrame(8'hA5, 1'b0, 1'b0, 8'h00);

    applyStimulus(8'h07, 1'b1);
    checkFrame(8'h07, 1'b0, 1'b0, 8'h00);

    applyStimulus(8'h81, 1'b1);
    checkFrame(8'h81, 1'b0, 1'b1, 8'h3C);
    checkIdle("after 81 idle", 20);

    // 0x55 then 0xAA with data_valid held: second start falls right after the tx_done cycle
    applyStimulus(8'h55, 1'b1);
    checkFrame(8'h55, 1'b1, 1'b0, 8'h00);
    checkFrame(8'hAA, 1'b0, 1'b0, 8'h00);
    checkIdle("after AA idle", 4);

    // reset in the middle of data bit 3
    applyStimulus(8'hA5, 1'b1);
    for (int i = 0; i < 69; i++) begin
      @(negedge clk);
      if (i == 0) data_valid = 1'b0;
    end
    checkOutput("pre-abort bit3 serial", serial_out, 1'b0);
    checkOutput("pre-abort busy", tx_busy, 1'b1);
    #2 reset = 1'b0;
    #1;
    checkOutput("abort serial", serial_out, 1'b1);
    checkOutput("abort busy", tx_busy, 1'b0);
    checkOutput("abort done", tx_done, 1'b0);
    checkIdle("in reset", 3);
    reset = 1'b1;
    checkIdle("after abort idle", 20);

    applyStimulus(8'h01, 1'b1);
    checkFrame(8'h01, 1'b0, 1'b0, 8'h00);

    applyStimulus(8'hFF, 1'b1);
    checkFrame(8'hFF, 1'b0, 1'b0, 8'h00);
    checkIdle("final idle", 5);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
    $finish;
  end

endmodule

// File: doc/tx_uart.md
Name: tx_uart

Overview:
- UART transmitter: parallel byte in, asynchronous serial frame out. It is the transmit-side counterpart to the existing Rx path.
- Frame format: start bit (0), data LSB-first, optional even parity bit, one stop bit (1). Even parity matches the Rx checker.
- Sits between a host-side byte source (valid/busy handshake) and the TX pin; single clock domain, no synchronizer needed on the output.

Parameters:
- INPUT_DATA_WIDTH, 8, data bits per frame.
- CLKS_PER_BIT, 16, clk cycles per serial bit. Legal range is >= 2; the baud counter is $clog2(CLKS_PER_BIT) bits wide.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset. Asserted while 0.
- tx_data  input  INPUT_DATA_WIDTH  byte to send; sampled only on acceptance.
- data_valid  input  1  request to send tx_data.
- serial_out  output  1  TX line; registered; idles high.
- tx_busy  output  1  high from the cycle after acceptance until the stop bit completes.
- tx_done  output  1  one-cycle pulse marking frame completion.

Behaviour:
- Reset (reset==0, async): state=IDLE, serial_out=1, tx_busy=0, tx_done=0, counters=0, shift register=0.
- States and transitions:
  - IDLE: serial_out=1. If data_valid==1, capture tx_data into the shift register, compute parity = XOR of the captured bits, and go to START.
  - START: serial_out=0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: serial_out=shift[0]; shift right every CLKS_PER_BIT cycles. After INPUT_DATA_WIDTH bits, go to PARITY (or to STOP when the feature is compiled out).
  - PARITY: serial_out=parity for CLKS_PER_BIT cycles, then go to STOP.
  - STOP: serial_out=1 for CLKS_PER_BIT cycles, then go to IDLE.
- Timing:
  - Acceptance happens at the edge where state==IDLE and data_valid==1. serial_out falls and tx_busy rises on that same edge, so both are visible the next cycle.
  - Frame length from the start-bit falling edge to the return to IDLE: (INPUT_DATA_WIDTH+3)*CLKS_PER_BIT cycles. With defaults this is 176.
- tx_done: asserted for exactly one cycle, in the first IDLE cycle after STOP. tx_busy is 0 in that same cycle.
- Back-to-back frames:
  - data_valid held high, or asserted in the tx_done cycle, is accepted in that same IDLE cycle.
  - The minimum stop-bit high time is therefore CLKS_PER_BIT+1 cycles.
  - The minimum spacing between start-bit falling edges is (INPUT_DATA_WIDTH+3)*CLKS_PER_BIT+1 cycles.
- data_valid while tx_busy==1 is ignored: no queuing, no error, and the frame in flight is unaffected.
- tx_data changing after acceptance has no effect on the current frame.
- Baud counter: counts 0..CLKS_PER_BIT-1 and wraps to 0 on each bit boundary. The bit index counts 0..INPUT_DATA_WIDTH-1 in DATA.
- Reset mid-frame: the frame is aborted immediately, serial_out is forced to 1 and tx_done is not pulsed. The next frame needs a fresh data_valid after reset deasserts.
- No X on any output after reset, including when data_valid is X while busy.

Optional Feature:
- Macro: TX_PARITY_EN.
- Defined: the PARITY state is present and frames are 8E1 for defaults. This is the default build, matching the Rx parity check.
- Undefined: the PARITY state and parity logic are removed. DATA goes directly to STOP, frames are 8N1, and frame length is (INPUT_DATA_WIDTH+2)*CLKS_PER_BIT (160 cycles with defaults).

Test Plan:
- Async reset asserted mid-cycle with no clk edge -> serial_out=1, tx_busy=0 and tx_done=0 immediately.
- Send 0xA5 with defaults and TX_PARITY_EN -> line bits 0,1,0,1,0,0,1,0,1,0(parity),1, each held 16 cycles. tx_done pulses 176 cycles after the start-bit fall.
- Send 0x07 -> data bits 1,1,1,0,0,0,0,0, parity bit=1. A loopback into the Rx path yields received_data=0x07 and rx_error=0.
- Pulse data_valid with 0x3C at cycle 50 of a frame carrying 0x81 -> only 0x81 is transmitted; the line stays high after STOP.
- Hold data_valid high with 0x55 then 0xAA -> two frames whose start falls are exactly 177 cycles apart, with the stop bit high for 17 cycles.
- Assert reset during DATA bit 3 -> serial_out=1 and no tx_done. After release, sending 0x01 -> a clean full frame.
- Without TX_PARITY_EN, send 0xFF -> 10-bit frame, with the stop bit directly after data bit 7 and tx_done at cycle 160.
